io_port_bank: RTL and testbench
===============================

# io_port_bank

Parametrised memory-mapped I/O port bank for the RISC core, replacing the single fixed 16-bit port. It provides NUM_PORTS independent output latches and input ports. Each input port has change detection with sticky per-bit flags, a per-bit interrupt mask and a combined interrupt request. It sits on the core's data-memory bus and decodes only accesses with address bit 15 set.

## Interface

**Parameters**
- DATA_WIDTH, 16, width of each port and of the bus data.
- NUM_PORTS, 4, number of ports; range 1..16.
- PORT_BITS, 2, port-index field width; must be at least clog2(NUM_PORTS), minimum 1.

**Ports**
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- io_access_addr  in  16  bus address; bit 15 = I/O space, bits [1:0] = register select, bits [2+PORT_BITS-1:2] = port index.
- io_in  in  DATA_WIDTH  write data.
- io_write_en  in  1  write strobe.
- io_read_en  in  1  read strobe.
- io_out  out  DATA_WIDTH  read data, combinational.
- io_read_device  in  NUM_PORTS*DATA_WIDTH  external inputs; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- io_write_device  out  NUM_PORTS*DATA_WIDTH  output latches, packed the same way as io_read_device.
- io_irq  out  1  OR over all ports of (EDGE & MASK).

## Operation

**Decode**
- An access is valid when io_access_addr[15]=1 and port index < NUM_PORTS.
- Invalid writes are ignored. Invalid reads, and any cycle with io_read_en=0, drive io_out=0.

**Registers per port** (select = addr[1:0])
- 0 OUT: read/write. Drives that port's slice of io_write_device.
- 1 IN: read-only. Holds the sampled input value; writes are ignored.
- 2 EDGE: sticky per-bit change flags, write-1-to-clear.
- 3 MASK: read/write interrupt enable, per bit.

**Input path**
- The sample stage captures io_read_device every cycle. IN reads the last stage.
- PREV holds the previous IN value. While armed, EDGE |= IN ^ PREV every cycle.

**Settle counter**
- After reset, a small counter suppresses EDGE updates until the pipeline holds real data. The block is disarmed until the counter reaches SETTLE cycles:
  - SETTLE = 3 with IO_SYNC_EN defined.
  - SETTLE = 2 without it.
- The counter saturates at SETTLE; the block then stays armed until the next reset.

**Collisions**
- Write-1-to-clear on EDGE and a new change on the same bit in the same cycle: the set wins and the bit stays 1.
- Read and write to the same register in the same cycle: io_out returns the pre-write value.

**Reset values**
- OUT, io_write_device, EDGE, MASK, sync stages, PREV and the settle counter are all 0.
- io_irq=0. io_out=0 while io_read_en=0.

## Timing

- OUT write: io_write_device updates on the same edge that captures the write. There are 0 cycles of added latency.
- Read: io_out is valid in the same cycle as io_read_en, from registered state.
- With IO_SYNC_EN, for an input change set up before edge k:
  - IN shows the new value after edge k+1.
  - The EDGE bit sets at edge k+2.
  - io_irq rises after edge k+2, provided the MASK bit is set.
- Without IO_SYNC_EN, each of the above is one edge earlier.
- io_irq is a combinational AND/OR of registers and carries no further delay.
- Clearing EDGE drops io_irq after the clearing edge.
- A reset assertion mid-operation clears all state immediately. After release the settle window applies again.

## Configuration

- IO_SYNC_EN defined: two flip-flop synchroniser per input bit, for asynchronous external inputs. SETTLE=3.
- IO_SYNC_EN undefined: single sample register; inputs must be synchronous to clk. SETTLE=2.

## Test plan

- Reset: hold rst_n=0 with io_read_device all 0xFFFF, then release. Required: io_write_device=0, io_irq=0, and all EDGE registers read 0 through the settle window and afterwards (the input never changes).
- OUT write: write 0xA5A5 to addr 0x8004 (port 1 OUT). Required: bits [31:16] of io_write_device = 0xA5A5 after that edge; reading 0x8004 returns 0xA5A5; other ports are unchanged.
- Decode: write 0x1234 to 0x0004 (bit 15 clear), and with NUM_PORTS=3 write to port index 3. Required: no change to any register; reads of both addresses return 0.
- Edge and interrupt: write MASK port 0 = 0x0001, then toggle io_read_device[0] from 0 to 1. Required: EDGE port 0 = 0x0001 and io_irq=1 at the specified edge for the build under test. Writing 0x0001 to 0x8002 then clears io_irq.
- Set wins: issue the W1C write of EDGE bit 0 in the same cycle that a new bit-0 change reaches the EDGE update. Required: EDGE bit 0 stays 1.
- Latency per macro: run the same toggle with IO_SYNC_EN defined and undefined. Required: the EDGE-set edge differs by exactly one cycle.

Source files
------------

// File: rtl/io_bus_if.sv
// Data-memory bus slice seen by the I/O port bank: address, write data, strobes and read data.
interface io_bus_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic [15:0]           io_access_addr;
  logic [DATA_WIDTH-1:0] io_in;
  logic                  io_write_en;
  logic                  io_read_en;
  logic [DATA_WIDTH-1:0] io_out;

  modport master (
    output io_access_addr, io_in, io_write_en, io_read_en,
    input  io_out
  );

  modport slave (
    input  io_access_addr, io_in, io_write_en, io_read_en,
    output io_out
  );
endinterface

// File: rtl/io_port_bank.sv
// Memory-mapped bank of output latches and change-detecting input ports with a combined IRQ.
// Define IO_SYNC_EN for a two-flop input synchroniser (settle window 3) instead of one sample flop.
module io_port_bank #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned PORT_BITS  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  io_bus_if.slave                         bus,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] io_read_device,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] io_write_device,
  output logic                            io_irq
);

`ifdef IO_SYNC_EN
  localparam int unsigned SETTLE = 3;
`else
  localparam int unsigned SETTLE = 2;
`endif

  typedef logic [DATA_WIDTH-1:0] word_t;

  logic [PORT_BITS-1:0] port_idx;
  logic [1:0]           reg_sel;
  logic                 sel_ok;
  logic                 armed;
  logic [1:0]           settle_q;
  logic                 unused_addr;

  word_t out_q  [NUM_PORTS];
  word_t in_q   [NUM_PORTS];
  word_t prev_q [NUM_PORTS];
  word_t edge_q [NUM_PORTS];
  word_t mask_q [NUM_PORTS];
  word_t edge_d [NUM_PORTS];
  logic  wr_port[NUM_PORTS];
`ifdef IO_SYNC_EN
  word_t meta_q [NUM_PORTS];
`endif

  assign port_idx    = bus.io_access_addr[2 +: PORT_BITS];
  assign reg_sel     = bus.io_access_addr[1:0];
  assign sel_ok      = bus.io_access_addr[15] && (32'(port_idx) < NUM_PORTS);
  assign armed       = (settle_q == 2'(SETTLE));
  assign unused_addr = ^bus.io_access_addr;

  // W1C clear is applied before the new change bits are OR'ed in, so a simultaneous set wins.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_port[p] = bus.io_write_en && sel_ok && (port_idx == PORT_BITS'(p));
      edge_d[p]  = edge_q[p];
      if (wr_port[p] && (reg_sel == 2'd2)) edge_d[p] = edge_d[p] & ~bus.io_in;
      if (armed) edge_d[p] = edge_d[p] | (in_q[p] ^ prev_q[p]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_q[p]  <= '0;
        in_q[p]   <= '0;
        prev_q[p] <= '0;
        edge_q[p] <= '0;
        mask_q[p] <= '0;
`ifdef IO_SYNC_EN
        meta_q[p] <= '0;
`endif
      end
    end else begin
      if (!armed) settle_q <= settle_q + 2'd1;
      for (int p = 0; p < NUM_PORTS; p++) begin
`ifdef IO_SYNC_EN
        meta_q[p] <= io_read_device[p*DATA_WIDTH +: DATA_WIDTH];
        in_q[p]   <= meta_q[p];
`else
        in_q[p]   <= io_read_device[p*DATA_WIDTH +: DATA_WIDTH];
`endif
        prev_q[p] <= in_q[p];
        edge_q[p] <= edge_d[p];
        if (wr_port[p] && (reg_sel == 2'd0)) out_q[p]  <= bus.io_in;
        if (wr_port[p] && (reg_sel == 2'd3)) mask_q[p] <= bus.io_in;
      end
    end
  end

  always_comb begin
    io_irq = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      io_write_device[p*DATA_WIDTH +: DATA_WIDTH] = out_q[p];
      io_irq = io_irq | (|(edge_q[p] & mask_q[p]));
    end
  end

  always_comb begin
    bus.io_out = '0;
    if (bus.io_read_en && sel_ok) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_idx == PORT_BITS'(p)) begin
          unique case (reg_sel)
            2'd0:    bus.io_out = out_q[p];
            2'd1:    bus.io_out = in_q[p];
            2'd2:    bus.io_out = edge_q[p];
            default: bus.io_out = mask_q[p];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Randomised self-checking bench for io_port_bank against a history-based behavioural model.
module tb_io_port_bank;
  localparam int unsigned DW = 16;
  localparam int unsigned NP = 3;
  localparam int unsigned PB = 2;
  localparam int unsigned W  = NP * DW;
`ifdef IO_SYNC_EN
  localparam int L = 2;
  localparam int SETTLE = 3;
`else
  localparam int L = 1;
  localparam int SETTLE = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] dev;
  logic [W-1:0] wdev;
  logic         irq;

  io_bus_if #(.DATA_WIDTH(DW)) bus ();

  io_port_bank #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .PORT_BITS(PB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .io_read_device  (dev),
    .io_write_device (wdev),
    .io_irq          (irq)
  );

  always #5 clk = ~clk;

  // Model: register contents plus the full history of driven input values since reset.
  logic [DW-1:0] m_out [NP];
  logic [DW-1:0] m_mask[NP];
  logic [DW-1:0] m_edge[NP];
  logic [W-1:0]  devh[$];
  int            ecount;
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] rd_obs, rd_exp;

  // Value visible in IN after edge j: the input driven before edge j-L+1.
  function automatic logic [W-1:0] in_at(int j);
    int m;
    m = j - L + 1;
    if (m < 1) return '0;
    return devh[m-1];
  endfunction

  function automatic logic [DW-1:0] m_read(logic [15:0] a, logic re);
    int idx;
    logic [W-1:0] v;
    idx = int'(a[2 +: PB]);
    if (!re || !a[15] || idx >= NP) return '0;
    case (a[1:0])
      2'd0: return m_out[idx];
      2'd1: begin v = in_at(ecount); return v[idx*DW +: DW]; end
      2'd2: return m_edge[idx];
      default: return m_mask[idx];
    endcase
  endfunction

  function automatic logic m_irq();
    logic r;
    r = 1'b0;
    for (int p = 0; p < NP; p++) r = r | (|(m_edge[p] & m_mask[p]));
    return r;
  endfunction

  function automatic logic [W-1:0] m_wdev();
    logic [W-1:0] v;
    for (int p = 0; p < NP; p++) v[p*DW +: DW] = m_out[p];
    return v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_out[p] = '0; m_mask[p] = '0; m_edge[p] = '0;
    end
    devh.delete();
    ecount = 0;
  endtask

  task automatic model_edge(logic [15:0] a, logic [DW-1:0] d, logic we, logic [W-1:0] dv);
    logic [W-1:0] chg;
    int idx;
    ecount++;
    // Changes are only meaningful once both compared samples came from real input data.
    chg = (ecount > SETTLE) ? (in_at(ecount-1) ^ in_at(ecount-2)) : '0;
    devh.push_back(dv);
    idx = int'(a[2 +: PB]);
    if (we && a[15] && idx < NP) begin
      case (a[1:0])
        2'd0: m_out[idx] = d;
        2'd2: m_edge[idx] = m_edge[idx] & ~d;
        2'd3: m_mask[idx] = d;
        default: ;
      endcase
    end
    for (int p = 0; p < NP; p++) m_edge[p] = m_edge[p] | chg[p*DW +: DW];
  endtask

  task automatic step(logic [15:0] a, logic [DW-1:0] d, logic we, logic re, logic [W-1:0] dv);
    @(negedge clk);
    bus.io_access_addr = a; bus.io_in = d; bus.io_write_en = we; bus.io_read_en = re; dev = dv;
    #1;
    rd_obs = bus.io_out;
    rd_exp = m_read(a, re);
    @(posedge clk);
    model_edge(a, d, we, dv);
    #1;
  endtask

  task automatic apply_reset(logic [W-1:0] dv);
    rst_n = 1'b0;
    dev = dv;
    bus.io_write_en = 1'b0; bus.io_read_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if (wdev !== '0) begin miscompares++; $display("FAIL rst_wdev: got %h want 0", wdev); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq: got %b want 0", irq); end
    vectors++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset('1);
    for (int i = 0; i < 8; i++) begin
      step(16'h8002 | 16'((i % NP) << 2), '0, 1'b0, 1'b1, '1);
      if (rd_obs !== 16'h0) begin
        miscompares++; $display("FAIL settle_edge%0d: got %h want 0000", i, rd_obs);
      end
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL settle_irq%0d: got %b want 0", i, irq); end
      vectors++;
    end
  endtask

  task automatic test_out_write();
    step(16'h8004, 16'hA5A5, 1'b1, 1'b0, dev);
    if (wdev[31:16] !== 16'hA5A5) begin
      miscompares++; $display("FAIL out_slice: got %h want a5a5", wdev[31:16]);
    end
    vectors++;
    if (wdev !== m_wdev()) begin miscompares++; $display("FAIL out_all: got %h want %h", wdev, m_wdev()); end
    vectors++;
    step(16'h8004, '0, 1'b0, 1'b1, dev);
    if (rd_obs !== 16'hA5A5) begin miscompares++; $display("FAIL out_read: got %h want a5a5", rd_obs); end
    vectors++;
  endtask

  task automatic test_decode();
    step(16'h0004, 16'h1234, 1'b1, 1'b0, dev);
    step(16'h800C, 16'h5678, 1'b1, 1'b0, dev);
    step(16'h800F, 16'hFFFF, 1'b1, 1'b0, dev);
    if (wdev !== {16'h0, 16'hA5A5, 16'h0}) begin
      miscompares++; $display("FAIL dec_wdev: got %h want %h", wdev, {16'h0, 16'hA5A5, 16'h0});
    end
    vectors++;
    step(16'h0004, '0, 1'b0, 1'b1, dev);
    if (rd_obs !== 16'h0) begin miscompares++; $display("FAIL dec_rd_lo: got %h want 0000", rd_obs); end
    vectors++;
    step(16'h800C, '0, 1'b0, 1'b1, dev);
    if (rd_obs !== 16'h0) begin miscompares++; $display("FAIL dec_rd_p3: got %h want 0000", rd_obs); end
    vectors++;
    step(16'h8004, '0, 1'b0, 1'b0, dev);
    if (rd_obs !== 16'h0) begin miscompares++; $display("FAIL dec_no_re: got %h want 0000", rd_obs); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL dec_irq: got %b want 0", irq); end
    vectors++;
  endtask

  task automatic test_edge_irq();
    int lat;
    repeat (5) step(16'h0, '0, 1'b0, 1'b0, '0);
    for (int p = 0; p < NP; p++) step(16'h8002 | 16'(p << 2), 16'hFFFF, 1'b1, 1'b0, '0);
    step(16'h8003, 16'h0001, 1'b1, 1'b0, '0);
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_pre: got %b want 0", irq); end
    vectors++;
    step(16'h0, '0, 1'b0, 1'b0, W'(1));
    lat = 0;
    while (irq !== 1'b1 && lat < 10) begin
      step(16'h0, '0, 1'b0, 1'b0, W'(1));
      lat++;
    end
    if (lat !== L) begin miscompares++; $display("FAIL irq_latency: got %0d edges want %0d", lat, L); end
    vectors++;
    step(16'h8002, '0, 1'b0, 1'b1, W'(1));
    if (rd_obs !== 16'h0001) begin miscompares++; $display("FAIL edge_p0: got %h want 0001", rd_obs); end
    vectors++;
    step(16'h8002, 16'h0001, 1'b1, 1'b0, W'(1));
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b want 0", irq); end
    vectors++;
  endtask

  task automatic test_set_wins();
    step(16'h0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < L - 1; i++) step(16'h0, '0, 1'b0, 1'b0, '0);
    step(16'h8002, 16'h0001, 1'b1, 1'b0, '0);
    if (irq !== 1'b1) begin miscompares++; $display("FAIL setwin_irq: got %b want 1", irq); end
    vectors++;
    step(16'h8002, '0, 1'b0, 1'b1, '0);
    if (rd_obs !== 16'h0001) begin miscompares++; $display("FAIL setwin_edge: got %h want 0001", rd_obs); end
    vectors++;
  endtask

  task automatic test_random();
    logic [63:0]  r;
    logic [W-1:0] dv;
    logic [15:0]  a;
    logic         we, re;
    apply_reset('0);
    dv = '0;
    for (int i = 0; i < 400; i++) begin
      a  = 16'($urandom) & 16'h000F;
      a[15] = ($urandom % 8) != 0;
      we = ($urandom % 3) == 0;
      re = ($urandom % 4) != 0;
      if ($urandom % 3 == 0) begin
        r  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        dv = dv ^ r[W-1:0];
      end
      step(a, 16'($urandom), we, re, dv);
      if (re) begin
        if (rd_obs !== rd_exp) begin
          miscompares++; $display("FAIL rnd_read%0d: addr %h got %h want %h", i, a, rd_obs, rd_exp);
        end
        vectors++;
      end
      if (wdev !== m_wdev()) begin
        miscompares++; $display("FAIL rnd_wdev%0d: got %h want %h", i, wdev, m_wdev());
      end
      vectors++;
      if (irq !== m_irq()) begin
        miscompares++; $display("FAIL rnd_irq%0d: got %b want %b", i, irq, m_irq());
      end
      vectors++;
    end
  endtask

  task automatic test_midreset();
    logic [W-1:0] dv;
    repeat (3) step(16'h8003, 16'hFFFF, 1'b1, 1'b0, dev ^ W'(3));
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.io_write_en = 1'b0; bus.io_read_en = 1'b1; bus.io_access_addr = 16'h8003;
    model_reset();
    #1;
    if (wdev !== '0) begin miscompares++; $display("FAIL mid_wdev: got %h want 0", wdev); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL mid_irq: got %b want 0", irq); end
    vectors++;
    if (bus.io_out !== 16'h0) begin miscompares++; $display("FAIL mid_mask: got %h want 0000", bus.io_out); end
    vectors++;
    dv = {16'h1357, 16'h9BDF, 16'h2468};
    dev = dv;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(16'h8002 | 16'((i % NP) << 2), '0, 1'b0, 1'b1, dv);
      if (rd_obs !== 16'h0) begin
        miscompares++; $display("FAIL mid_settle%0d: got %h want 0000", i, rd_obs);
      end
      vectors++;
    end
    step(16'h8001, '0, 1'b0, 1'b1, dv);
    if (rd_obs !== 16'h2468) begin miscompares++; $display("FAIL mid_in: got %h want 2468", rd_obs); end
    vectors++;
  endtask

  initial begin
    bus.io_access_addr = '0; bus.io_in = '0; bus.io_write_en = 1'b0; bus.io_read_en = 1'b0;
    dev = '0;
    test_reset();
    test_out_write();
    test_decode();
    test_edge_irq();
    test_set_wins();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
